// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM duty-capture block.
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int DUTY_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DUTY_MAX        = (1 << DUTY_W_DEF) - 1;

endpackage

// File: rtl/pwm_duty_divider.sv
// Restoring divider producing floor(numer * 2**DUTY_W / denom), one quotient bit per cycle,
// saturating at all-ones.
module pwm_duty_divider
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  numer_i,
  input  logic [CNT_W-1:0]  denom_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] quot_o
);

  localparam int REM_W = CNT_W + 1;
  localparam int BIT_W = $clog2(DUTY_W + 1);

  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_d;
  logic [REM_W-1:0]  rem_shift;
  logic [CNT_W-1:0]  den_q;
  logic [DUTY_W-1:0] quot_q;
  logic [BIT_W-1:0]  bits_q;
  logic              sat_q;
  logic              busy_q;
  logic              done_q;
  logic              ge;

  // Quotient bits above DUTY_W-1 are non-zero only when numer >= denom, which is
  // exactly the saturating case, so only the low DUTY_W bits are iterated.
  always_comb begin
    rem_shift = {rem_q[CNT_W-1:0], 1'b0};
    ge        = rem_shift >= {1'b0, den_q};
    rem_d     = ge ? (rem_shift - {1'b0, den_q}) : rem_shift;
  end

  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      bits_q <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        rem_q  <= {1'b0, numer_i};
        den_q  <= denom_i;
        quot_q <= '0;
        bits_q <= BIT_W'(DUTY_W);
        sat_q  <= numer_i >= denom_i;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quot_q <= DUTY_W'({quot_q, ge});
        bits_q <= bits_q - BIT_W'(1);
        if (bits_q == BIT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = sat_q ? '1 : quot_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Samples an asynchronous PWM input and reports period, high time and duty fraction.
// A missing rising edge for 2**CNT_W-1 cycles flags the line as stuck high or low.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic              meas_valid,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              stuck_high,
  output logic              stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_s_dly_q;
  logic                   rise;
  logic                   timeout;
  pwm_state_e             state_q;
  logic [CNT_W-1:0]       period_ctr_q;
  logic [CNT_W-1:0]       high_ctr_q;
  logic [CNT_W-1:0]       period_cnt_q;
  logic [CNT_W-1:0]       high_cnt_q;
  logic                   meas_valid_q;
  logic [DUTY_W-1:0]      duty_q;
  logic                   duty_valid_q;
  logic                   stuck_high_q;
  logic                   stuck_low_q;
  logic                   div_start;
  logic                   div_busy;
  logic                   div_done;
  logic [DUTY_W-1:0]      div_quot;

  assign pwm_s     = sync_q[SYNC_STAGES-1];
  assign rise      = pwm_s & ~pwm_s_dly_q;
  // A rise in the final counting cycle is still a normal capture.
  assign timeout   = (state_q == MEASURE) && !rise && (period_ctr_q == CNT_MAX);
  assign div_start = (state_q == MEASURE) && rise && !div_busy;

  pwm_duty_divider #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .abort_i (timeout),
    .numer_i (high_ctr_q),
    .denom_i (period_ctr_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      pwm_s_dly_q  <= 1'b0;
      state_q      <= IDLE;
      period_ctr_q <= '0;
      high_ctr_q   <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_s_dly_q  <= pwm_s;
      meas_valid_q <= 1'b0;
      duty_valid_q <= 1'b0;
      if (div_done) begin
        duty_q       <= div_quot;
        duty_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q      <= MEASURE;
            period_ctr_q <= CNT_ONE;
            high_ctr_q   <= CNT_ONE;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cnt_q <= period_ctr_q;
            high_cnt_q   <= high_ctr_q;
            meas_valid_q <= 1'b1;
            period_ctr_q <= CNT_ONE;
            high_ctr_q   <= CNT_ONE;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
          end else if (timeout) begin
            // Overrides any divider result landing in the same cycle.
            state_q      <= IDLE;
            stuck_high_q <= pwm_s;
            stuck_low_q  <= ~pwm_s;
            duty_q       <= pwm_s ? '1 : '0;
            duty_valid_q <= 1'b1;
          end else begin
            period_ctr_q <= period_ctr_q + CNT_ONE;
            if (pwm_s) begin
              high_ctr_q <= high_ctr_q + CNT_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_cnt = period_cnt_q;
  assign high_cnt   = high_cnt_q;
  assign meas_valid = meas_valid_q;
  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomised and directed bench for pwm_duty_capture, checked against a waveform-level model.
module tb_pwm_duty_capture;

  localparam int CNT_W    = 8;
  localparam int DUTY_W   = 8;
  localparam int SYNC     = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int DUTY_TOP = (1 << DUTY_W) - 1;
  localparam int LAT      = SYNC + 1;  // drive of a rise -> meas_valid

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pwm_in = 1'b0;
  logic [CNT_W-1:0]  period_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic              meas_valid;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              stuck_high;
  logic              stuck_low;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_cyc[$], m_per[$], m_high[$];
  int d_cyc[$], d_val[$], d_sh[$], d_sl[$];
  int pat_h[$], pat_l[$], rise_at[$];

  pwm_duty_capture #(
    .CNT_W       (CNT_W),
    .DUTY_W      (DUTY_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .duty       (duty),
    .duty_valid (duty_valid),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (meas_valid) begin
        m_cyc.push_back(cyc);
        m_per.push_back(int'(period_cnt));
        m_high.push_back(int'(high_cnt));
        $display("[%0d] meas period=%0d high=%0d", cyc, period_cnt, high_cnt);
      end
      if (duty_valid) begin
        d_cyc.push_back(cyc);
        d_val.push_back(int'(duty));
        d_sh.push_back(int'(stuck_high));
        d_sl.push_back(int'(stuck_low));
        $display("[%0d] duty=%0d stuck_high=%0d stuck_low=%0d", cyc, duty, stuck_high, stuck_low);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int exp_duty(int h, int p);
    int q;
    q = (h * (1 << DUTY_W)) / p;
    return (q > DUTY_TOP) ? DUTY_TOP : q;
  endfunction

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_cyc.delete(); m_per.delete(); m_high.delete();
    d_cyc.delete(); d_val.delete(); d_sh.delete(); d_sl.delete();
  endtask

  task automatic set_pat(int h, int l, int n, bit clear);
    if (clear) begin
      pat_h.delete();
      pat_l.delete();
    end
    repeat (n) begin
      pat_h.push_back(h);
      pat_l.push_back(l);
    end
  endtask

  // Drives every queued period, then one closing rise held for final_high cycles (0 = forever).
  task automatic drive_pattern(int final_high);
    rise_at.delete();
    foreach (pat_h[i]) begin
      @(negedge clk);
      pwm_in = 1'b1;
      rise_at.push_back(cyc);
      repeat (pat_h[i] - 1) @(negedge clk);
      @(negedge clk);
      pwm_in = 1'b0;
      repeat (pat_l[i] - 1) @(negedge clk);
    end
    @(negedge clk);
    pwm_in = 1'b1;
    rise_at.push_back(cyc);
    if (final_high > 0) begin
      repeat (final_high) @(negedge clk);
      pwm_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (period_cnt !== '0 || high_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counts: got period=%0h high=%0h want 0", period_cnt, high_cnt);
    end
    checks++;
    if (duty !== '0 || duty_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_duty: got duty=%0h valid=%0b want 0", duty, duty_valid);
    end
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_meas_valid: got %0b want 0", meas_valid);
    end
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      errors++;
      $display("FAIL reset_stuck: got high=%0b low=%0b want 0", stuck_high, stuck_low);
    end
  endtask

  task automatic test_pattern(string name);
    int n, exp_c, last;
    int e_cyc[$], e_val[$];
    do_reset(3);
    drive_pattern(1);
    repeat (DUTY_W + 20) @(negedge clk);
    n = pat_h.size();
    checks++;
    if (m_cyc.size() !== n) begin
      errors++;
      $display("FAIL %s meas_count: got %0d want %0d", name, m_cyc.size(), n);
    end
    last = -1000;
    for (int i = 0; i < n; i++) begin
      exp_c = rise_at[i+1] + LAT;
      if (i < m_cyc.size()) begin
        checks++;
        if (m_cyc[i] !== exp_c || m_per[i] !== pat_h[i] + pat_l[i] || m_high[i] !== pat_h[i]) begin
          errors++;
          $display("FAIL %s meas[%0d]: got cyc=%0d period=%0d high=%0d want cyc=%0d period=%0d high=%0d",
                   name, i, m_cyc[i], m_per[i], m_high[i], exp_c, pat_h[i] + pat_l[i], pat_h[i]);
        end
      end
      // A capture starts the divider only if the previous divide has finished.
      if (exp_c - last >= DUTY_W + 1) begin
        e_cyc.push_back(exp_c + DUTY_W + 1);
        e_val.push_back(exp_duty(pat_h[i], pat_h[i] + pat_l[i]));
        last = exp_c;
      end
    end
    checks++;
    if (d_cyc.size() !== e_cyc.size()) begin
      errors++;
      $display("FAIL %s duty_count: got %0d want %0d", name, d_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < d_cyc.size(); i++) begin
      checks++;
      if (d_cyc[i] !== e_cyc[i] || d_val[i] !== e_val[i]) begin
        errors++;
        $display("FAIL %s duty[%0d]: got cyc=%0d duty=%0d want cyc=%0d duty=%0d",
                 name, i, d_cyc[i], d_val[i], e_cyc[i], e_val[i]);
      end
    end
  endtask

  task automatic test_stuck(bit lvl);
    int exp_t, nm, k;
    do_reset(3);
    set_pat(3, 7, 2, 1'b1);
    drive_pattern(lvl ? 0 : 3);
    exp_t = rise_at[2] + LAT + CNT_MAX;
    repeat (CNT_MAX + 20) @(negedge clk);
    checks++;
    if (m_cyc.size() !== 2 || d_cyc.size() !== 3) begin
      errors++;
      $display("FAIL stuck%0d counts: got meas=%0d duty=%0d want meas=2 duty=3", lvl, m_cyc.size(), d_cyc.size());
    end
    if (d_cyc.size() > 0) begin
      k = d_cyc.size() - 1;
      checks++;
      if (d_cyc[k] !== exp_t || d_val[k] !== (lvl ? DUTY_TOP : 0) || d_sh[k] !== int'(lvl) || d_sl[k] !== int'(!lvl)) begin
        errors++;
        $display("FAIL stuck%0d timeout: got cyc=%0d duty=%0d sh=%0d sl=%0d want cyc=%0d duty=%0d sh=%0d sl=%0d",
                 lvl, d_cyc[k], d_val[k], d_sh[k], d_sl[k], exp_t, lvl ? DUTY_TOP : 0, lvl, !lvl);
      end
    end
    checks++;
    if (stuck_high !== lvl || stuck_low !== !lvl) begin
      errors++;
      $display("FAIL stuck%0d hold: got sh=%0b sl=%0b want sh=%0b sl=%0b", lvl, stuck_high, stuck_low, lvl, !lvl);
    end
    nm = m_cyc.size();
    @(negedge clk);
    if (lvl) begin
      pwm_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      errors++;
      $display("FAIL stuck%0d clear: got sh=%0b sl=%0b want 0", lvl, stuck_high, stuck_low);
    end
    checks++;
    if (m_cyc.size() !== nm) begin
      errors++;
      $display("FAIL stuck%0d no_meas_after_idle_rise: got %0d meas want %0d", lvl, m_cyc.size(), nm);
    end
    pwm_in = 1'b0;
  endtask

  task automatic test_reset_mid_divide();
    int m0, n;
    bit seen;
    do_reset(3);
    set_pat(3, 12, 5, 1'b1);
    m0 = 0;
    seen = 1'b0;
    fork
      drive_pattern(1);
      begin
        n = 0;
        while (!seen && n < 200) begin
          @(negedge clk);
          n++;
          if (meas_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL rst_mid first_meas: no meas_valid within 200 cycles");
        end else begin
          m0 = cyc;
          repeat (3) @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          checks++;
          if ({period_cnt, high_cnt, duty, meas_valid, duty_valid, stuck_high, stuck_low} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got period=%0d high=%0d duty=%0d mv=%0b dv=%0b want all 0",
                     period_cnt, high_cnt, duty, meas_valid, duty_valid);
          end
          repeat (2) @(negedge clk);
          rst = 1'b0;
        end
      end
    join
    repeat (DUTY_W + 20) @(negedge clk);
    checks++;
    if (m_cyc.size() !== 4 || d_cyc.size() !== 3) begin
      errors++;
      $display("FAIL rst_mid counts: got meas=%0d duty=%0d want meas=4 duty=3", m_cyc.size(), d_cyc.size());
    end
    for (int i = 1; i < 4 && i < m_cyc.size(); i++) begin
      checks++;
      if (m_cyc[i] !== rise_at[i+2] + LAT || m_per[i] !== 15 || m_high[i] !== 3) begin
        errors++;
        $display("FAIL rst_mid meas[%0d]: got cyc=%0d period=%0d high=%0d want cyc=%0d period=15 high=3",
                 i, m_cyc[i], m_per[i], m_high[i], rise_at[i+2] + LAT);
      end
    end
    for (int i = 0; i < 3 && i < d_cyc.size(); i++) begin
      checks++;
      if (d_cyc[i] !== rise_at[i+3] + LAT + DUTY_W + 1 || d_val[i] !== exp_duty(3, 15)) begin
        errors++;
        $display("FAIL rst_mid duty[%0d]: got cyc=%0d duty=%0d want cyc=%0d duty=%0d (aborted m=%0d)",
                 i, d_cyc[i], d_val[i], rise_at[i+3] + LAT + DUTY_W + 1, exp_duty(3, 15), m0);
      end
    end
  endtask

  initial begin
    test_reset();

    set_pat(3, 7, 4, 1'b1);
    test_pattern("duty_3_7");

    set_pat(5, 5, 3, 1'b1);
    set_pat(9, 1, 3, 1'b0);
    test_pattern("switch_5_5_to_9_1");

    set_pat(1, 1, 20, 1'b1);
    test_pattern("min_period");

    pat_h.delete();
    pat_l.delete();
    for (int i = 0; i < 12; i++) begin
      pat_h.push_back(int'($urandom_range(10, 1)));
      pat_l.push_back(int'($urandom_range(10, 1)));
    end
    test_pattern("random");

    test_stuck(1'b0);
    test_stuck(1'b1);
    test_reset_mid_divide();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
